// File: rtl/circuito_cl.sv
// Target-shooting game controller: an LFSR picks a row/column target, two players
// take turns entering moves, hits score on a saturating counter, and a timer passes the turn.
module circuito_cl #(
    parameter int TIMEOUT = 25000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] jogadaFileira,
    input  logic [3:0] jogadaColuna,
    input  logic       temJogada,
    input  logic       terminar,
    output logic [6:0] pontos1,
    output logic [6:0] pontos2,
    output logic       errou,
    output logic       db_acertou,
    output logic [6:0] linhaEsperada,
    output logic [6:0] colunaEsperada,
    output logic [6:0] db_estado,
    output logic [3:0] db_linha_tb,
    output logic [3:0] db_coluna_tb
);

    localparam int TW = ($clog2(TIMEOUT) > 15) ? $clog2(TIMEOUT) : 15;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        INICIAL   = 4'h0,
        PREPARA   = 4'h1,
        NOVO_ALVO = 4'h2,
        ESPERA    = 4'h3,
        REGISTRA  = 4'h4,
        COMPARA   = 4'h5,
        ACERTOU   = 4'h6,
        ERROU     = 4'h7,
        TROCA     = 4'h8,
        FIM       = 4'hF
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [2:0]    alvo_lin_q, alvo_lin_d;
    logic [2:0]    alvo_col_q, alvo_col_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    jog_lin_q, jog_lin_d;
    logic [3:0]    jog_col_q, jog_col_d;
    logic          tem_q;
    logic          jogador_q, jogador_d;
    logic          errou_q, errou_d;
    logic [3:0]    pontos [2];
    logic          tem_rise;
    logic          acerto;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tem_rise = temJogada & ~tem_q;
    assign acerto   = (jog_lin_q == {1'b0, alvo_lin_q}) && (jog_col_q == {1'b0, alvo_col_q});
    // Taps 8,6,5,4 of the Fibonacci LFSR map to bits 7,5,4,3.
    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:   if (iniciar) estado_d = PREPARA;
            PREPARA:   estado_d = NOVO_ALVO;
            NOVO_ALVO: estado_d = ESPERA;
            ESPERA: begin
                if (terminar)                estado_d = FIM;
                else if (timer_q == TIMER_MAX) estado_d = TROCA;
                else if (tem_rise)           estado_d = REGISTRA;
            end
            REGISTRA:  estado_d = COMPARA;
            COMPARA:   estado_d = acerto ? ACERTOU : ERROU;
            ACERTOU:   estado_d = NOVO_ALVO;
            ERROU:     estado_d = ESPERA;
            TROCA:     estado_d = NOVO_ALVO;
            FIM:       if (iniciar) estado_d = PREPARA;
            default:   estado_d = INICIAL;
        endcase
        if (terminar && estado_q != INICIAL) estado_d = FIM;
    end

    always_comb begin
        alvo_lin_d = alvo_lin_q;
        alvo_col_d = alvo_col_q;
        timer_d    = timer_q;
        jog_lin_d  = jog_lin_q;
        jog_col_d  = jog_col_q;
        jogador_d  = jogador_q;
        errou_d    = errou_q;
        case (estado_q)
            PREPARA: begin
                jogador_d = 1'b0;
                errou_d   = 1'b0;
            end
            NOVO_ALVO: begin
                alvo_lin_d = lfsr_q[5:3];
                alvo_col_d = lfsr_q[2:0];
                timer_d    = '0;
                errou_d    = 1'b0;
            end
            ESPERA:   timer_d = timer_q + 1'b1;
            REGISTRA: begin
                jog_lin_d = jogadaFileira;
                jog_col_d = jogadaColuna;
            end
            ERROU:    errou_d = 1'b1;
            TROCA: begin
                jogador_d = ~jogador_q;
                errou_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            lfsr_q     <= 8'h01;
            alvo_lin_q <= '0;
            alvo_col_q <= '0;
            timer_q    <= '0;
            jog_lin_q  <= '0;
            jog_col_q  <= '0;
            tem_q      <= 1'b0;
            jogador_q  <= 1'b0;
            errou_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            lfsr_q     <= lfsr_d;
            alvo_lin_q <= alvo_lin_d;
            alvo_col_q <= alvo_col_d;
            timer_q    <= timer_d;
            jog_lin_q  <= jog_lin_d;
            jog_col_q  <= jog_col_d;
            tem_q      <= temJogada;
            jogador_q  <= jogador_d;
            errou_q    <= errou_d;
        end
    end

    // One saturating score counter per player; index 0 is player 1.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pontos
            logic [3:0] pts_q, pts_d;

            always_comb begin
                pts_d = pts_q;
                if (estado_q == PREPARA)
                    pts_d = '0;
                else if (estado_q == ACERTOU && jogador_q == 1'(gi) && pts_q != 4'hF)
                    pts_d = pts_q + 4'd1;
            end

            always_ff @(posedge clock) begin
                if (reset) pts_q <= '0;
                else       pts_q <= pts_d;
            end

            assign pontos[gi] = pts_q;
        end
    endgenerate

    assign pontos1        = hex7(pontos[0]);
    assign pontos2        = hex7(pontos[1]);
    assign errou          = errou_q;
    assign db_acertou     = (estado_q == ACERTOU);
    assign linhaEsperada  = hex7({1'b0, alvo_lin_q});
    assign colunaEsperada = hex7({1'b0, alvo_col_q});
    assign db_estado      = hex7(estado_q);
    assign db_linha_tb    = {1'b0, alvo_lin_q};
    assign db_coluna_tb   = {1'b0, alvo_col_q};

endmodule

// File: tb/tb_circuito_cl.sv
// Randomized bench for circuito_cl against a move-level game model (scores, player, target).
module tb_circuito_cl;

    localparam int TO = 64;

    logic       clock = 1'b0;
    logic       reset, iniciar, temJogada, terminar;
    logic [3:0] jf, jc;
    logic [6:0] pontos1, pontos2, linhaEsperada, colunaEsperada, db_estado;
    logic       errou, db_acertou;
    logic [3:0] db_linha_tb, db_coluna_tb;

    circuito_cl #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogadaFileira(jf), .jogadaColuna(jc), .temJogada(temJogada), .terminar(terminar),
        .pontos1(pontos1), .pontos2(pontos2), .errou(errou), .db_acertou(db_acertou),
        .linhaEsperada(linhaEsperada), .colunaEsperada(colunaEsperada), .db_estado(db_estado),
        .db_linha_tb(db_linha_tb), .db_coluna_tb(db_coluna_tb)
    );

    always #5 clock = ~clock;

    // Free-running reference LFSR, reset together with the DUT.
    logic [7:0] m;
    int cyc = 0;
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) m <= 8'h01;
        else       m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end

    int n_vec = 0, n_bad = 0;
    int sc [2];
    int player;
    logic [2:0] tr, tc;
    logic exp_errou;
    int latch_cyc;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_p1"},   32'(pontos1), 32'(hex7(4'(sc[0]))));
        check_eq({tag, "_p2"},   32'(pontos2), 32'(hex7(4'(sc[1]))));
        check_eq({tag, "_err"},  32'(errou), 32'(exp_errou));
        check_eq({tag, "_lin"},  32'(db_linha_tb), 32'({1'b0, tr}));
        check_eq({tag, "_col"},  32'(db_coluna_tb), 32'({1'b0, tc}));
        check_eq({tag, "_lin7"}, 32'(linhaEsperada), 32'(hex7({1'b0, tr})));
        check_eq({tag, "_col7"}, 32'(colunaEsperada), 32'(hex7({1'b0, tc})));
    endtask

    task automatic start_game(input string tag);
        logic [7:0] cap;
        iniciar = 1'b1;
        tick(); check_eq({tag, "_st1"}, 32'(db_estado), 32'(hex7(4'h1)));
        tick(); check_eq({tag, "_st2"}, 32'(db_estado), 32'(hex7(4'h2)));
        cap = m;
        tick(); check_eq({tag, "_st3"}, 32'(db_estado), 32'(hex7(4'h3)));
        latch_cyc = cyc;
        tick(); tick();
        iniciar = 1'b0;
        sc[0] = 0; sc[1] = 0; player = 0; exp_errou = 1'b0;
        tr = cap[5:3]; tc = cap[2:0];
        check_outputs(tag);
        $display("start %s: target row %0d col %0d", tag, tr, tc);
    endtask

    task automatic do_move(input bit correct, input string tag);
        logic [3:0] r, c;
        logic [7:0] cap;
        int pulses, sel;
        r = {1'b0, tr};
        c = {1'b0, tc};
        if (!correct) begin
            sel = $urandom_range(0, 2);
            if (sel != 1) r = r ^ 4'($urandom_range(1, 15));
            if (sel != 0) c = c ^ 4'($urandom_range(1, 15));
        end
        jf = r; jc = c; temJogada = 1'b1;
        pulses = 0; cap = '0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 2) temJogada = 1'b0;
            if (db_acertou === 1'b1) pulses++;
            if (k == 4) cap = m;
            if (k == 5 && correct) latch_cyc = cyc;
        end
        if (correct) begin
            if (sc[player] < 15) sc[player]++;
            tr = cap[5:3]; tc = cap[2:0];
            exp_errou = 1'b0;
        end else begin
            exp_errou = 1'b1;
        end
        check_eq({tag, "_pulse"}, 32'(pulses), 32'(correct));
        check_outputs(tag);
        $display("move %s: player %0d row %0d col %0d hit %0d scores %0d/%0d",
                 tag, player + 1, r, c, correct, sc[0], sc[1]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit found, prev_wrong, wrong;
        int elapsed;
        logic [7:0] cap;

        reset = 1'b1; iniciar = 1'b0; temJogada = 1'b0; terminar = 1'b0; jf = '0; jc = '0;
        sc[0] = 0; sc[1] = 0; player = 0; tr = '0; tc = '0; exp_errou = 1'b0;
        repeat (3) tick();
        check_eq("rst_state", 32'(db_estado), 32'(hex7(4'h0)));
        check_eq("rst_acertou", 32'(db_acertou), 32'd0);
        check_outputs("rst");
        reset = 1'b0;
        tick(); tick();
        check_eq("idle_state", 32'(db_estado), 32'(hex7(4'h0)));

        start_game("g1");
        do_move(1'b1, "p1_hit");
        do_move(1'b0, "p1_miss");

        // Miss leaves the target; the timer still expires and hands the turn over.
        found = 1'b0;
        cap = '0;
        for (int k = 0; k < TO + 20 && !found; k++) begin
            tick();
            if (errou === 1'b0) begin
                found = 1'b1;
                cap = m;
            end
        end
        elapsed = cyc - latch_cyc;
        check_eq("timeout_seen", 32'(found), 32'd1);
        check_eq("timeout_window", 32'(elapsed >= TO && elapsed <= TO + 8), 32'd1);
        tick();
        player = 1; tr = cap[5:3]; tc = cap[2:0]; exp_errou = 1'b0;
        check_eq("troca_state", 32'(db_estado), 32'(hex7(4'h3)));
        check_outputs("troca");
        $display("turn passed after %0d cycles: target row %0d col %0d", elapsed, tr, tc);

        do_move(1'b1, "p2_hit");

        // Random hits/misses for player 2, enough hits to reach the saturation point.
        prev_wrong = 1'b0;
        for (int i = 0; i < 36; i++) begin
            wrong = !prev_wrong && ($urandom_range(0, 3) == 0);
            do_move(!wrong, "p2_rand");
            prev_wrong = wrong;
        end

        terminar = 1'b1;
        repeat (10) tick();
        terminar = 1'b0;
        check_eq("fim_state", 32'(db_estado), 32'(hex7(4'hF)));
        check_outputs("fim");

        // A move while in FIM must be ignored.
        jf = {1'b0, tr}; jc = {1'b0, tc}; temJogada = 1'b1;
        begin
            int pulses = 0;
            for (int k = 1; k <= 6; k++) begin
                tick();
                if (k == 2) temJogada = 1'b0;
                if (db_acertou === 1'b1) pulses++;
            end
            check_eq("fim_move_pulse", 32'(pulses), 32'd0);
        end
        check_eq("fim_hold_state", 32'(db_estado), 32'(hex7(4'hF)));
        check_outputs("fim_move");

        start_game("g2");
        do_move(1'b1, "g2_hit");

        reset = 1'b1;
        tick();
        sc[0] = 0; sc[1] = 0; player = 0; tr = '0; tc = '0; exp_errou = 1'b0;
        check_eq("midrst_state", 32'(db_estado), 32'(hex7(4'h0)));
        check_outputs("midrst");
        reset = 1'b0;
        tick();
        check_eq("midrst_idle", 32'(db_estado), 32'(hex7(4'h0)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
